// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master frame controller.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2
    } state_e;

    localparam int FRAME_BITS_DEFAULT = 8;

    // Width of a counter that holds 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div.sv
// Serial clock generator: sck toggles every WAIT_CLKS clk cycles, parked at POL while hold_i.
// Latency: first toggle WAIT_CLKS cycles after hold_i drops; no backpressure.
module clk_div #(
    parameter logic POL       = 1'b1,
    parameter int   WAIT_CLKS = 4
) (
    input  logic clk,
    input  logic hold_i,
    output logic sck_o
);

    localparam int CW = (WAIT_CLKS > 1) ? $clog2(WAIT_CLKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CLKS - 1);

    logic [CW-1:0] cnt_q;
    logic          sck_q;

    always_ff @(posedge clk) begin
        if (hold_i) begin
            cnt_q <= '0;
            sck_q <= POL;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            sck_q <= ~sck_q;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign sck_o = sck_q;

endmodule

// File: rtl/spi_master_ctrl_sync.sv
// Brings the returned sck into the clk domain and flags its rising edges.
// Latency: rise_o asserts 2-3 clk cycles after the real sck edge; no backpressure.
module spi_master_ctrl_sync #(
    parameter logic SCK_IDLE = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sck_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic sync3_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= SCK_IDLE;
            sync2_q <= SCK_IDLE;
            sync3_q <= SCK_IDLE;
        end else begin
            sync1_q <= sck_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // sync3 only feeds edge detection; sync2 is the first metastability-safe copy.
    assign rise_o = sync2_q & ~sync3_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master frame controller: drives ss and the clk_div enable, transferring whole frames only.
// Latency: ss falls 1 clk after en, en_sck 1 clk later; ends 2-3 clk after the last sck rise.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int   FRAME_BITS = FRAME_BITS_DEFAULT,
    parameter logic SCK_IDLE   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sck,
    output logic ss,
    output logic en_sck
);

    localparam int CW = cnt_width(FRAME_BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BITS - 1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          ss_q;
    logic          en_sck_q;
    logic          sck_rise;

    spi_master_ctrl_sync #(
        .SCK_IDLE (SCK_IDLE)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .sck_i  (sck),
        .rise_o (sck_rise)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ss_q     <= 1'b1;
            en_sck_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_q <= SETUP;
                        ss_q    <= 1'b0;
                    end
                    cnt_q <= '0;
                end
                SETUP: begin
                    state_q  <= XFER;
                    en_sck_q <= 1'b1;
                    cnt_q    <= '0;
                end
                XFER: begin
                    // en is only looked at on the edge that closes a frame.
                    if (sck_rise) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q <= '0;
                            if (!en) begin
                                state_q  <= IDLE;
                                ss_q     <= 1'b1;
                                en_sck_q <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    cnt_q    <= '0;
                    ss_q     <= 1'b1;
                    en_sck_q <= 1'b0;
                end
            endcase
        end
    end

    assign ss     = ss_q;
    assign en_sck = en_sck_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench: controller plus clk_div (POL=1, WAIT_CLKS=4), edge-count scoreboard per transfer.
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic sck;
    logic ss;
    logic en_sck;
    logic hold;

    int checks = 0;
    int errors = 0;

    int   n_edges = 0;
    int   since_edge = 0;
    logic sck_d1 = 1'b1;
    int   exp_q[$];
    int   start_edges;

    always #3 clk = ~clk;

    assign hold = !rst || !en_sck;

    clk_div #(
        .POL       (1'b1),
        .WAIT_CLKS (4)
    ) u_div (
        .clk    (clk),
        .hold_i (hold),
        .sck_o  (sck)
    );

    spi_master_ctrl #(
        .FRAME_BITS (8),
        .SCK_IDLE   (1'b1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .sck    (sck),
        .ss     (ss),
        .en_sck (en_sck)
    );

    // Independent sck rising-edge counter, one clk behind the real edge.
    always @(posedge clk) begin
        sck_d1 <= sck;
        if (sck && !sck_d1) begin
            n_edges    <= n_edges + 1;
            since_edge <= 0;
        end else begin
            since_edge <= since_edge + 1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t required below 300000", $time);
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_edges(input string tag, input int n);
        int t = 0;
        while ((n_edges - start_edges) < n && t < 800) begin
            step();
            t++;
        end
        check(tag, ((n_edges - start_edges) >= n) ? 1 : 0, 1);
    endtask

    // Waits for ss to rise, pops the expected edge count and checks the idle period after.
    task automatic frame_end_check(input string tag);
        int t = 0;
        int exp_edges;
        int e0;
        bit bad;
        while (ss !== 1'b1 && t < 800) begin
            step();
            t++;
        end
        check({tag, "_ss_rise"}, int'(ss), 1);
        check({tag, "_en_sck_low"}, int'(en_sck), 0);
        check({tag, "_latency_le3"}, (since_edge <= 3) ? 1 : 0, 1);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_nonempty"}, 0, 1);
        end else begin
            exp_edges = exp_q.pop_front();
            check({tag, "_edges"}, n_edges - start_edges, exp_edges);
        end
        e0  = n_edges;
        bad = 1'b0;
        repeat (24) begin
            step();
            if (ss !== 1'b1 || en_sck !== 1'b0) bad = 1'b1;
        end
        check({tag, "_steady"}, int'(bad), 0);
        check({tag, "_no_extra_edges"}, n_edges - e0, 0);
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        step(3);
        rst = 1'b1;
        check("reset_ss", int'(ss), 1);
        check("reset_en_sck", int'(en_sck), 0);
        step(4);
        check("idle_ss", int'(ss), 1);

        // One-clock request: single frame.
        start_edges = n_edges;
        exp_q.push_back(8);
        en = 1'b1;
        step();
        en = 1'b0;
        check("pulse_ss_low", int'(ss), 0);
        check("pulse_en_sck_setup", int'(en_sck), 0);
        step();
        check("pulse_en_sck_high", int'(en_sck), 1);
        check("pulse_ss_still_low", int'(ss), 0);
        frame_end_check("single");

        // Held request dropped one clk after the 24th edge: three back-to-back frames.
        start_edges = n_edges;
        exp_q.push_back(24);
        en = 1'b1;
        wait_edges("three_wait24", 24);
        en = 1'b0;
        frame_end_check("three");

        // Request withdrawn mid-frame: the frame still completes.
        start_edges = n_edges;
        exp_q.push_back(8);
        en = 1'b1;
        wait_edges("mid_wait3", 3);
        en = 1'b0;
        check("mid_ss_low", int'(ss), 0);
        check("mid_en_sck_high", int'(en_sck), 1);
        frame_end_check("mid");

        // Reset during a frame, with en still high.
        start_edges = n_edges;
        en = 1'b1;
        wait_edges("abort_wait4", 4);
        rst = 1'b0;
        step();
        check("abort_ss", int'(ss), 1);
        check("abort_en_sck", int'(en_sck), 0);
        step();
        start_edges = n_edges;
        step(2);
        check("rst_beats_en_ss", int'(ss), 1);
        rst = 1'b1;
        en  = 1'b0;
        step(30);
        check("abort_no_edges", n_edges - start_edges, 0);
        check("abort_idle_ss", int'(ss), 1);

        // Recovery: a fresh frame after the abort is a full 8 edges.
        start_edges = n_edges;
        exp_q.push_back(8);
        en = 1'b1;
        step();
        en = 1'b0;
        frame_end_check("recover");

        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
